// File: rtl/gbf_port_arbiter_pkg.sv
// Shared definitions for the global-buffer SPI port arbiter: requester map,
// default outbound mask and FSM state encoding.
package gbf_port_arbiter_pkg;

    localparam int NUM_REQ_DEF = 7;

    localparam int CFG_IDX    = 0;
    localparam int FLGWEI_IDX = 1;
    localparam int WEI_IDX    = 2;
    localparam int FLGACT_IDX = 3;
    localparam int ACT_IDX    = 4;
    localparam int FLGOFM_IDX = 5;
    localparam int OFM_IDX    = 6;

    // A set bit marks a requester that reads the GBF out through the pad.
    localparam logic [NUM_REQ_DEF-1:0] RD_MASK_DEF = 7'b110_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TURN    = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } gbf_state_e;

endpackage

// File: rtl/gbf_port_arbiter_rr_pick.sv
// Combinational round-robin selector over requesters 1..NUM_REQ-1. The search
// starts one bit above the pointer and wraps from the top bit back to bit 1.
module rr_pick #(
    parameter int NUM_REQ = 7,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:1] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gntOh,
    output logic               valid
);

    localparam int RR_N = NUM_REQ - 1;

    // Position p in the ring is requester bit p+1; the bit after ptr sits at p=ptr.
    always_comb begin
        int startPos;
        int pos;
        gntOh    = '0;
        valid    = 1'b0;
        pos      = 0;
        startPos = int'(ptr);
        if (startPos >= RR_N) begin
            startPos = 0;
        end
        for (int k = 0; k < RR_N; k++) begin
            pos = startPos + k;
            if (pos >= RR_N) begin
                pos = pos - RR_N;
            end
            if (!valid && req[pos+1]) begin
                gntOh[pos+1] = 1'b1;
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gbf_port_arbiter.sv
// Grants the half-duplex SPI data port to one requester per burst, owns the
// port direction and pad enable, and inserts turnaround cycles on direction flips.
module gbf_port_arbiter
    import gbf_port_arbiter_pkg::*;
#(
    parameter int                 NUM_REQ   = NUM_REQ_DEF,
    parameter logic [NUM_REQ-1:0] RD_MASK   = RD_MASK_DEF,
    parameter int                 BURST_LEN = 16,
    parameter int                 TURN_CYC  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] Req,
    input  logic               Beat_Val,
    input  logic               Beat_Last,
    output logic [NUM_REQ-1:0] Gnt,
    output logic               Switch_RdWr,
    output logic               pad_OE,
    output logic               Busy,
    output gbf_state_e         dbgState
);

    localparam int CNT_W  = $clog2(BURST_LEN + 1);
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);

    gbf_state_e         state;
    logic [NUM_REQ-1:0] winOh;
    logic [PTR_W-1:0]   winIdx;
    logic [PTR_W-1:0]   rrPtr;
    logic [CNT_W-1:0]   beatCnt;
    logic [TURN_W-1:0]  turnCnt;

    logic [NUM_REQ-1:0] rrOh;
    logic               rrValid;
    logic [NUM_REQ-1:0] pickOh;
    logic               pickVal;
    logic [PTR_W-1:0]   pickIdx;
    logic               pickInbound;
    logic               winOutbound;
    logic               winStillReq;
    logic [CNT_W-1:0]   beatNext;
    logic               beatEnd;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req   (Req[NUM_REQ-1:1]),
        .ptr   (rrPtr),
        .gntOh (rrOh),
        .valid (rrValid)
    );

    // Configuration fetch always pre-empts the round-robin group.
    always_comb begin
        pickOh  = '0;
        pickVal = 1'b0;
        if (Req[CFG_IDX]) begin
            pickOh[CFG_IDX] = 1'b1;
            pickVal         = 1'b1;
        end else if (rrValid) begin
            pickOh  = rrOh;
            pickVal = 1'b1;
        end
    end

    always_comb begin
        pickIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickOh[i]) begin
                pickIdx = PTR_W'(i);
            end
        end
    end

    assign pickInbound = ~|(pickOh & RD_MASK);
    assign winOutbound = |(winOh & RD_MASK);
    assign winStillReq = |(winOh & Req);

    // A beat is one word moved while Beat_Val is high in a GRANT cycle. There is
    // no back-pressure: Gnt is the ready side, and Beat_Last counts only with Beat_Val.
    assign beatNext = beatCnt + CNT_W'(1);
    assign beatEnd  = Beat_Val && (Beat_Last || (beatNext == BURST_MAX));

    assign dbgState = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            Gnt         <= '0;
            Switch_RdWr <= 1'b1;
            pad_OE      <= 1'b0;
            Busy        <= 1'b0;
            beatCnt     <= '0;
            rrPtr       <= '0;
            turnCnt     <= '0;
            winOh       <= '0;
            winIdx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pickVal) begin
                        winOh  <= pickOh;
                        winIdx <= pickIdx;
                        Busy   <= 1'b1;
                        if (pickInbound == Switch_RdWr) begin
                            state  <= GRANT;
                            Gnt    <= pickOh;
                            pad_OE <= ~pickInbound;
                        end else begin
                            state       <= TURN;
                            Switch_RdWr <= ~Switch_RdWr;
                            pad_OE      <= 1'b0;
                            turnCnt     <= '0;
                        end
                    end
                end

                // The direction is already flipped; the winner may withdraw meanwhile.
                TURN: begin
                    if (turnCnt == TURN_LAST) begin
                        if (winStillReq) begin
                            state  <= GRANT;
                            Gnt    <= winOh;
                            pad_OE <= winOutbound;
                        end else begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end
                    end else begin
                        turnCnt <= turnCnt + TURN_W'(1);
                    end
                end

                GRANT: begin
                    if (Beat_Val) begin
                        beatCnt <= beatNext;
                        if (beatEnd) begin
                            state  <= RELEASE;
                            Gnt    <= '0;
                            pad_OE <= 1'b0;
                        end
                    end
                end

                RELEASE: begin
                    beatCnt <= '0;
                    if (winIdx != PTR_W'(CFG_IDX)) begin
                        rrPtr <= winIdx;
                    end
                    state <= IDLE;
                    Busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gbf_port_arbiter.sv
// Directed bench for gbf_port_arbiter: reset, burst length/Last, direction
// turnaround, round-robin order with CFG priority, and reset mid-grant.
module tb_gbf_port_arbiter;
    import gbf_port_arbiter_pkg::*;

    localparam logic [6:0] R_NONE   = 7'b000_0000;
    localparam logic [6:0] R_CFG    = 7'b000_0001;
    localparam logic [6:0] R_FLGWEI = 7'b000_0010;
    localparam logic [6:0] R_WEI    = 7'b000_0100;
    localparam logic [6:0] R_FLGACT = 7'b000_1000;
    localparam logic [6:0] R_ACT    = 7'b001_0000;
    localparam logic [6:0] R_OFM    = 7'b100_0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] Req;
    logic       Beat_Val;
    logic       Beat_Last;
    logic [6:0] Gnt;
    logic       Switch_RdWr;
    logic       pad_OE;
    logic       Busy;
    gbf_state_e dbgState;

    int errors = 0;
    int checks = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    gbf_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Req         (Req),
        .Beat_Val    (Beat_Val),
        .Beat_Last   (Beat_Last),
        .Gnt         (Gnt),
        .Switch_RdWr (Switch_RdWr),
        .pad_OE      (pad_OE),
        .Busy        (Busy),
        .dbgState    (dbgState)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Req = R_NONE; Beat_Val = 1'b0; Beat_Last = 1'b0;
        tick();
        checks++; if (Gnt !== R_NONE) begin errors++; $display("FAIL reset_gnt: got %b expected %b", Gnt, R_NONE); end
        checks++; if (Switch_RdWr !== 1'b1) begin errors++; $display("FAIL reset_switch: got %b expected 1", Switch_RdWr); end
        checks++; if (pad_OE !== 1'b0) begin errors++; $display("FAIL reset_pad_oe: got %b expected 0", pad_OE); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        checks++; if (dbgState !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbgState, IDLE); end
        rst_n = 1'b1;
    endtask

    task automatic test_full_burst();
        logic [6:0] exp;
        Req = R_WEI;
        tick();
        checks++; if (Gnt !== R_WEI) begin errors++; $display("FAIL full_grant: got %b expected %b", Gnt, R_WEI); end
        checks++; if (Switch_RdWr !== 1'b1) begin errors++; $display("FAIL full_switch: got %b expected 1", Switch_RdWr); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", Busy); end
        Req = R_NONE; Beat_Val = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp = (i < 16) ? R_WEI : R_NONE;
            checks++; if (Gnt !== exp) begin errors++; $display("FAIL full_beat%0d: got %b expected %b", i, Gnt, exp); end
        end
        Beat_Val = 1'b0;
        checks++; if (dbgState !== RELEASE) begin errors++; $display("FAIL full_release: got %0d expected %0d", dbgState, RELEASE); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL full_release_busy: got %b expected 1", Busy); end
        tick();
        checks++; if (dbgState !== IDLE) begin errors++; $display("FAIL full_idle: got %0d expected %0d", dbgState, IDLE); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL full_idle_busy: got %b expected 0", Busy); end
    endtask

    task automatic test_beat_last();
        logic [6:0] exp;
        Req = R_WEI;
        tick();
        checks++; if (Gnt !== R_WEI) begin errors++; $display("FAIL last_grant: got %b expected %b", Gnt, R_WEI); end
        Req = R_NONE; Beat_Val = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            Beat_Last = (i == 3);
            tick();
            exp = (i < 3) ? R_WEI : R_NONE;
            checks++; if (Gnt !== exp) begin errors++; $display("FAIL last_beat%0d: got %b expected %b", i, Gnt, exp); end
        end
        Beat_Val = 1'b0; Beat_Last = 1'b0;
        tick();
        // Pointer sits at WEI (2): FLGACT (3) is next in line ahead of FLGWEI (1).
        Req = R_FLGWEI | R_FLGACT;
        tick();
        checks++; if (Gnt !== R_FLGACT) begin errors++; $display("FAIL last_ptr_pick: got %b expected %b", Gnt, R_FLGACT); end
        // A full 16-beat burst here proves the 3-beat count was cleared.
        Req = R_FLGWEI; Beat_Val = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp = (i < 16) ? R_FLGACT : R_NONE;
            checks++; if (Gnt !== exp) begin errors++; $display("FAIL clear_beat%0d: got %b expected %b", i, Gnt, exp); end
        end
        Beat_Val = 1'b0;
        tick();
        checks++; if (Gnt !== R_NONE) begin errors++; $display("FAIL gap_idle: got %b expected %b", Gnt, R_NONE); end
        tick();
        checks++; if (Gnt !== R_FLGWEI) begin errors++; $display("FAIL gap_next: got %b expected %b", Gnt, R_FLGWEI); end
        Req = R_NONE; Beat_Val = 1'b1; Beat_Last = 1'b1;
        tick();
        Beat_Val = 1'b0; Beat_Last = 1'b0;
        tick();
    endtask

    task automatic test_idle_beats();
        Req = R_NONE; Beat_Val = 1'b1; Beat_Last = 1'b1;
        tick();
        tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL idle_beats_busy: got %b expected 0", Busy); end
        checks++; if (Gnt !== R_NONE) begin errors++; $display("FAIL idle_beats_gnt: got %b expected %b", Gnt, R_NONE); end
        checks++; if (Switch_RdWr !== 1'b1) begin errors++; $display("FAIL idle_beats_switch: got %b expected 1", Switch_RdWr); end
        Beat_Val = 1'b0; Beat_Last = 1'b0;
    endtask

    task automatic test_dir_change_reset();
        Req = R_OFM;
        tick();
        checks++; if (Switch_RdWr !== 1'b0) begin errors++; $display("FAIL turn_switch: got %b expected 0", Switch_RdWr); end
        checks++; if (pad_OE !== 1'b0) begin errors++; $display("FAIL turn1_pad_oe: got %b expected 0", pad_OE); end
        checks++; if (Gnt !== R_NONE) begin errors++; $display("FAIL turn1_gnt: got %b expected %b", Gnt, R_NONE); end
        checks++; if (dbgState !== TURN) begin errors++; $display("FAIL turn1_state: got %0d expected %0d", dbgState, TURN); end
        tick();
        checks++; if (pad_OE !== 1'b0) begin errors++; $display("FAIL turn2_pad_oe: got %b expected 0", pad_OE); end
        checks++; if (Gnt !== R_NONE) begin errors++; $display("FAIL turn2_gnt: got %b expected %b", Gnt, R_NONE); end
        tick();
        checks++; if (Gnt !== R_OFM) begin errors++; $display("FAIL turn_grant: got %b expected %b", Gnt, R_OFM); end
        checks++; if (pad_OE !== 1'b1) begin errors++; $display("FAIL turn_grant_pad_oe: got %b expected 1", pad_OE); end
        // Dropping Req mid-grant must not end the burst.
        Req = R_NONE;
        tick();
        tick();
        checks++; if (Gnt !== R_OFM) begin errors++; $display("FAIL req_drop_gnt: got %b expected %b", Gnt, R_OFM); end
        rst_n = 1'b0;
        tick();
        checks++; if (Gnt !== R_NONE) begin errors++; $display("FAIL midrst_gnt: got %b expected %b", Gnt, R_NONE); end
        checks++; if (pad_OE !== 1'b0) begin errors++; $display("FAIL midrst_pad_oe: got %b expected 0", pad_OE); end
        checks++; if (Switch_RdWr !== 1'b1) begin errors++; $display("FAIL midrst_switch: got %b expected 1", Switch_RdWr); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", Busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_turn_drop();
        Req = R_OFM;
        tick();
        checks++; if (dbgState !== TURN) begin errors++; $display("FAIL drop_turn_state: got %0d expected %0d", dbgState, TURN); end
        Req = R_NONE;
        tick();
        tick();
        checks++; if (dbgState !== IDLE) begin errors++; $display("FAIL drop_state: got %0d expected %0d", dbgState, IDLE); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b expected 0", Busy); end
        checks++; if (Gnt !== R_NONE) begin errors++; $display("FAIL drop_gnt: got %b expected %b", Gnt, R_NONE); end
        checks++; if (Switch_RdWr !== 1'b0) begin errors++; $display("FAIL drop_switch: got %b expected 0", Switch_RdWr); end
        // Port is already outbound, so OFM is granted without a turnaround.
        Req = R_OFM;
        tick();
        checks++; if (Gnt !== R_OFM) begin errors++; $display("FAIL same_dir_gnt: got %b expected %b", Gnt, R_OFM); end
        checks++; if (pad_OE !== 1'b1) begin errors++; $display("FAIL same_dir_pad_oe: got %b expected 1", pad_OE); end
        Req = R_NONE; Beat_Val = 1'b1; Beat_Last = 1'b1;
        tick();
        Beat_Val = 1'b0; Beat_Last = 1'b0;
        checks++; if (pad_OE !== 1'b0) begin errors++; $display("FAIL release_pad_oe: got %b expected 0", pad_OE); end
        tick();
        Req = R_WEI;
        tick();
        checks++; if (Switch_RdWr !== 1'b1) begin errors++; $display("FAIL back_in_switch: got %b expected 1", Switch_RdWr); end
        checks++; if (Gnt !== R_NONE) begin errors++; $display("FAIL back_in_turn_gnt: got %b expected %b", Gnt, R_NONE); end
        tick();
        tick();
        checks++; if (Gnt !== R_WEI) begin errors++; $display("FAIL back_in_grant: got %b expected %b", Gnt, R_WEI); end
        checks++; if (pad_OE !== 1'b0) begin errors++; $display("FAIL back_in_pad_oe: got %b expected 0", pad_OE); end
        Req = R_NONE; Beat_Val = 1'b1; Beat_Last = 1'b1;
        tick();
        Beat_Val = 1'b0; Beat_Last = 1'b0;
        tick();
    endtask

    task automatic test_rr_order();
        logic [6:0] exp;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q = '{R_CFG, R_FLGWEI, R_WEI, R_ACT, R_FLGWEI, R_CFG};
        Req = R_CFG | R_FLGWEI | R_WEI | R_ACT;
        for (int g = 0; g < 6; g++) begin
            if (g == 5) Req[0] = 1'b1;
            for (int k = 0; k < 8 && Gnt === R_NONE; k++) tick();
            exp = exp_q.pop_front();
            checks++; if (Gnt !== exp) begin errors++; $display("FAIL rr_order%0d: got %b expected %b", g, Gnt, exp); end
            if (Gnt[0]) Req[0] = 1'b0;
            Beat_Val = 1'b1; Beat_Last = 1'b1;
            tick();
            Beat_Val = 1'b0; Beat_Last = 1'b0;
        end
        Req = R_NONE;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_burst();
        test_beat_last();
        test_idle_beats();
        test_dir_change_reset();
        test_turn_drop();
        test_rr_order();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gbf_port_arbiter.md
# gbf_port_arbiter

Sequences the single half-duplex SPI data port between the global-buffer requesters: configuration fetch, weight/activation flag and data writes (inbound), and OFM flag and data reads (outbound). It sits between the interface block and the TS3D core. It grants the port to one requester per burst and owns the port direction (`Switch_RdWr`) and the pad output enable, inserting turnaround cycles whenever the direction flips.

## Interface
Parameters:
- `NUM_REQ`, 7: number of requesters. Fixed map by bit: 0 CFG, 1 FLGWEI, 2 WEI, 3 FLGACT, 4 ACT, 5 FLGOFM, 6 OFM.
- `RD_MASK`, 7'b110_0000: a 1 marks an outbound requester (chip drives the pad).
- `BURST_LEN`, 16: maximum beats per grant.
- `TURN_CYC`, 2: turnaround cycles on a direction change; must be ≥1.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `Req`  in  NUM_REQ: per-requester request level, held until granted.
- `Beat_Val`  in  1: one word transferred on the port this cycle.
- `Beat_Last`  in  1: current beat ends the burst early; qualified by `Beat_Val`.
- `Gnt`  out  NUM_REQ: one-hot grant, or zero.
- `Switch_RdWr`  out  1: 1 = inbound (host writes the GBF), 0 = outbound (OFM read).
- `pad_OE`  out  1: pad output enable; 1 only while an outbound grant is active.
- `Busy`  out  1: high in any state other than IDLE.

## Operation
- Reset (`rst_n` low at a clock edge) forces the following after that edge, from any state:
  - state IDLE
  - `Gnt`=0, `Switch_RdWr`=1, `pad_OE`=0, `Busy`=0
  - beat count 0
  - round-robin pointer 0
- States: IDLE, TURN, GRANT, RELEASE.
- Arbitration in IDLE:
  - CFG (bit 0) has absolute priority.
  - Bits 1..6 are served round-robin, starting one bit above the last granted bit and wrapping from 6 to 1.
  - The winner is latched.
- IDLE transitions:
  - If the winner's direction (`RD_MASK` bit inverted) equals `Switch_RdWr`, go to GRANT.
  - Otherwise go to TURN and toggle `Switch_RdWr` on that edge; `pad_OE` goes to 0 on that edge.
- TURN:
  - Counts `TURN_CYC` cycles with `Gnt`=0 and `pad_OE`=0.
  - At the end, go to GRANT if the winner's `Req` is still high, else go to IDLE. The direction stays switched.
- GRANT:
  - `Gnt`=one-hot winner.
  - `pad_OE`=1 if the winner is outbound.
  - Each `Beat_Val` increments the beat count.
  - Go to RELEASE on a beat with `Beat_Last`, or on the beat that makes the count equal `BURST_LEN`.
- RELEASE:
  - One cycle with `Gnt`=0 and `pad_OE`=0. The beat count clears.
  - Update the round-robin pointer to the winner; CFG grants do not move the pointer.
  - Go to IDLE.
- `Beat_Val` outside GRANT is ignored.
- A `Req` drop during GRANT does not end the burst; only Last or `BURST_LEN` ends it.
- Beat count width is clog2(BURST_LEN+1); it never wraps.
- With no request, IDLE holds and `Switch_RdWr` keeps its last value.

## Timing
- `Req` is sampled at edge t in IDLE.
  - Same direction: `Gnt` is high from t+1.
  - Direction change: `Gnt` is high from t+TURN_CYC+1.
- The grant lasts from the first GRANT cycle through the cycle of the terminating beat. `Gnt` is low in the following cycle (RELEASE).
- Minimum gap between two grants is 2 cycles: RELEASE then IDLE.
- All outputs are registered. No combinational path runs from `Req` or `Beat_*` to any output.
- `pad_OE` never rises in the same cycle that `Switch_RdWr` changes. It stays low for at least `TURN_CYC`+1 cycles around every direction flip.

## Structure
- Shared package contents:
  - requester index constants (CFG..OFM)
  - the `RD_MASK` default
  - state encoding (IDLE=0, TURN=1, GRANT=2, RELEASE=3)
- One natural sub-module: `rr_pick`. It is a combinational round-robin selector over bits 1..6 with a pointer input and returns one-hot plus a valid flag.
- The FSM, counters and direction register live in the top.

## Test plan
- After reset, `Req`=7'b000_0100 (WEI) → `Gnt`=7'b000_0100 one cycle later and `Switch_RdWr` stays 1. With 16 `Beat_Val` and no Last → `Gnt` drops after the 16th beat, then a 1-cycle RELEASE.
- WEI burst ends with `Beat_Last` on beat 3 → the burst ends after 3 beats, the count clears, and the pointer advances to 2.
- `Req`=7'b100_0000 (OFM) while inbound → `Switch_RdWr`→0 at t+1, `pad_OE`=0 for cycles t+1..t+2, then `Gnt`[6]=1 and `pad_OE`=1 at t+3 (`TURN_CYC`=2).
- `Req`=7'b001_0111 held → the grant order is CFG, FLGWEI, WEI, ACT, FLGWEI…. CFG always wins when re-requested.
- OFM request drops during TURN → no grant, return to IDLE with `Switch_RdWr`=0.
- `rst_n` low mid-GRANT with `pad_OE`=1 → on the next edge `Gnt`=0, `pad_OE`=0, `Switch_RdWr`=1, `Busy`=0.
